k12a_boot_loader: RTL

//  Serial program loader upstream of the k12a core. Receives a framed image on a UART RX line.

---
 rtl/k12a_boot_loader_pkg.sv | 30 +++
 rtl/k12a_boot_loader_if.sv | 29 ++
 rtl/k12a_uart_rx.sv | 110 +++++++++++
 rtl/k12a_boot_loader.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/k12a_boot_loader_pkg.sv
// ============================================================================
// Module   : k12a_boot_loader_pkg
// Purpose  : Shared types and constants for the k12a serial boot loader.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package k12a_boot_loader_pkg;

  localparam logic [7:0] LOADER_SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_HI = 3'd1,
    ST_LEN_LO = 3'd2,
    ST_DATA   = 3'd3,
    ST_CSUM   = 3'd4,
    ST_ERROR  = 3'd5
  } loader_state_t;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

endpackage

`default_nettype wire

// File: rtl/k12a_boot_loader_if.sv
// ============================================================================
// Module   : k12a_boot_loader_if
// Purpose  : Serial input, memory write port and core-control outputs of the loader.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface k12a_boot_loader_if;
  logic        uart_rx;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data;
  logic        mem_write;
  logic        cpu_reset_n;
  logic        busy;
  logic        load_done;
  logic        load_error;

  modport master (
    input  uart_rx,
    output mem_addr, mem_data, mem_write, cpu_reset_n, busy, load_done, load_error
  );

  modport slave (
    output uart_rx,
    input  mem_addr, mem_data, mem_write, cpu_reset_n, busy, load_done, load_error
  );
endinterface

`default_nettype wire

// File: rtl/k12a_uart_rx.sv
// ============================================================================
// Module   : k12a_uart_rx
// Purpose  : 8N1 UART receiver with 2-flop synchroniser and centre sampling.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module k12a_uart_rx
  import k12a_boot_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic       cpu_clock,
  input  logic       reset,
  input  logic       uart_rx,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       framing_err
);

  localparam int             CW   = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]  HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0]  FULL = CW'(CLKS_PER_BIT - 1);

  logic          r_meta, r_sync, r_prev;
  rx_state_t     r_state, w_state;
  logic [CW-1:0] r_cnt, w_cnt;
  logic [2:0]    r_bits, w_bits;
  logic [7:0]    r_shift, w_shift;
  logic          r_valid, w_valid;
  logic          r_ferr, w_ferr;

  always_ff @(posedge cpu_clock) begin
    if (reset) begin
      r_meta  <= 1'b1;
      r_sync  <= 1'b1;
      r_prev  <= 1'b1;
      r_state <= RX_IDLE;
      r_cnt   <= '0;
      r_bits  <= '0;
      r_shift <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_meta  <= uart_rx;
      r_sync  <= r_meta;
      r_prev  <= r_sync;
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_bits  <= w_bits;
      r_shift <= w_shift;
      r_valid <= w_valid;
      r_ferr  <= w_ferr;
    end
  end

  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_bits  = r_bits;
    w_shift = r_shift;
    w_valid = 1'b0;
    w_ferr  = 1'b0;
    case (r_state)
      RX_IDLE: begin
        if (r_prev && !r_sync) begin
          w_state = RX_START;
          w_cnt   = '0;
        end
      end
      RX_START: begin
        // Glitches shorter than half a bit fall back to hunting.
        if (r_cnt == HALF) begin
          w_cnt   = '0;
          w_bits  = '0;
          w_state = r_sync ? RX_IDLE : RX_DATA;
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end
      RX_DATA: begin
        if (r_cnt == FULL) begin
          w_cnt   = '0;
          w_shift = {r_sync, r_shift[7:1]};
          if (r_bits == 3'd7) w_state = RX_STOP;
          else                w_bits  = r_bits + 1'b1;
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end
      RX_STOP: begin
        if (r_cnt == FULL) begin
          w_valid = r_sync;
          w_ferr  = !r_sync;
          w_state = RX_IDLE;
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end
      default: w_state = RX_IDLE;
    endcase
  end

  assign byte_data   = r_shift;
  assign byte_valid  = r_valid;
  assign framing_err = r_ferr;

endmodule

`default_nettype wire

// File: rtl/k12a_boot_loader.sv
// ============================================================================
// Module   : k12a_boot_loader
// Purpose  : Framed UART image loader; writes memory and holds the k12a core in
//            reset while loading. Optional checksum byte: K12A_LOADER_CHECKSUM_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module k12a_boot_loader
  import k12a_boot_loader_pkg::*;
#(
  parameter int          CLKS_PER_BIT = 104,
  parameter logic [15:0] LOAD_BASE    = 16'h0,
  parameter int          TIMEOUT_CLKS = 65535
) (
  input  logic                cpu_clock,
  input  logic                reset,
  k12a_boot_loader_if.master  bus
);

  localparam int            TW   = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [TW-1:0] TLIM = TW'(TIMEOUT_CLKS - 1);

  logic [7:0] byte_data;
  logic       byte_valid, framing_err;

  k12a_uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .cpu_clock   (cpu_clock),
    .reset       (reset),
    .uart_rx     (bus.uart_rx),
    .byte_data   (byte_data),
    .byte_valid  (byte_valid),
    .framing_err (framing_err)
  );

  loader_state_t r_state, w_state;
  logic [15:0]   r_len, w_len, r_idx, w_idx, r_addr, w_addr;
  logic [7:0]    r_data, w_data;
  logic [TW-1:0] r_tmo, w_tmo;
  logic          r_wr, w_wr, r_busy, w_busy, r_done, w_done, r_err, w_err, r_rstn, w_rstn;
  logic          w_active, w_sync, w_last, w_finish;

`ifdef K12A_LOADER_CHECKSUM_EN
  logic [7:0] r_csum, w_csum_sum;
  assign w_csum_sum = r_csum + byte_data;

  always_ff @(posedge cpu_clock) begin
    if (reset || !(r_state inside {ST_DATA, ST_CSUM}))
      r_csum <= '0;
    else if (r_state == ST_DATA && byte_valid)
      r_csum <= w_csum_sum;
  end
`endif

  always_ff @(posedge cpu_clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_len   <= '0;
      r_idx   <= '0;
      r_addr  <= LOAD_BASE;
      r_data  <= '0;
      r_tmo   <= '0;
      r_wr    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_rstn  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_len   <= w_len;
      r_idx   <= w_idx;
      r_addr  <= w_addr;
      r_data  <= w_data;
      r_tmo   <= w_tmo;
      r_wr    <= w_wr;
      r_busy  <= w_busy;
      r_done  <= w_done;
      r_err   <= w_err;
      r_rstn  <= w_rstn;
    end
  end

  always_comb begin
    w_state  = r_state;
    w_len    = r_len;
    w_idx    = r_idx;
    w_addr   = r_addr;
    w_data   = r_data;
    w_wr     = 1'b0;
    w_busy   = r_busy;
    w_done   = r_done;
    w_err    = r_err;
    w_rstn   = r_rstn;
    w_last   = 1'b0;
    w_finish = 1'b0;
    w_active = (r_state != ST_IDLE) && (r_state != ST_ERROR);
    w_sync   = byte_valid && (byte_data == LOADER_SYNC_BYTE);
    w_tmo    = (w_active && !byte_valid) ? r_tmo + 1'b1 : '0;

    case (r_state)
      ST_IDLE, ST_ERROR: begin
        // ERROR keeps the core held; only a clean IDLE lets it run.
        if (r_state == ST_IDLE) w_rstn = 1'b1;
        if (w_sync) begin
          w_state = ST_LEN_HI;
          w_busy  = 1'b1;
          w_rstn  = 1'b0;
          w_done  = 1'b0;
          w_err   = 1'b0;
        end
      end
      ST_LEN_HI: begin
        if (byte_valid) begin
          w_len[15:8] = byte_data;
          w_state     = ST_LEN_LO;
        end
      end
      ST_LEN_LO: begin
        if (byte_valid) begin
          w_len[7:0] = byte_data;
          w_idx      = '0;
          w_state    = ST_DATA;
          w_last     = ({r_len[15:8], byte_data} == 16'h0000);
        end
      end
      ST_DATA: begin
        if (byte_valid) begin
          w_wr   = 1'b1;
          w_addr = LOAD_BASE + r_idx;
          w_data = byte_data;
          w_idx  = r_idx + 16'd1;
          w_last = (r_idx == r_len - 16'd1);
        end
      end
`ifdef K12A_LOADER_CHECKSUM_EN
      ST_CSUM: begin
        if (byte_valid) begin
          if (w_csum_sum == 8'h00) begin
            w_finish = 1'b1;
          end else begin
            w_state = ST_ERROR;
            w_busy  = 1'b0;
            w_err   = 1'b1;
          end
        end
      end
`endif
      default: w_state = ST_IDLE;
    endcase

    if (w_last) begin
`ifdef K12A_LOADER_CHECKSUM_EN
      w_state = ST_CSUM;
`else
      w_finish = 1'b1;
`endif
    end

    if (w_finish) begin
      w_state = ST_IDLE;
      w_busy  = 1'b0;
      w_done  = 1'b1;
      w_rstn  = 1'b1;
    end

    if (w_active && (framing_err || (r_tmo == TLIM && !byte_valid))) begin
      w_state = ST_ERROR;
      w_busy  = 1'b0;
      w_err   = 1'b1;
      w_rstn  = 1'b0;
    end
  end

  assign bus.mem_addr    = r_addr;
  assign bus.mem_data    = r_data;
  assign bus.mem_write   = r_wr;
  assign bus.cpu_reset_n = r_rstn;
  assign bus.busy        = r_busy;
  assign bus.load_done   = r_done;
  assign bus.load_error  = r_err;

endmodule

`default_nettype wire
